// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder stage wrapped around the one-bit fa cell. An operand pair
// (a, b) and a carry-in are captured on an input valid/ready handshake. The
// sum is then formed LSB-first, one bit per clock, through a single fa
// instance with a registered carry. The WIDTH-bit sum and the final carry
// are presented on an output valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands on a/b/cin are valid
//   in_ready   stage can accept operands (high only in IDLE)
//   a, b       WIDTH-bit operands, sampled on the input handshake
//   cin        carry-in, sampled on the input handshake
//   out_valid  sum/cout hold a completed result (high only in HOLD)
//   out_ready  downstream accepts the result
//   sum        registered sum, (a + b + cin) mod 2^WIDTH
//   cout       registered carry-out of bit WIDTH-1
//
// Latency from the accepting edge to out_valid is exactly WIDTH clocks.
// With out_ready tied high, one operation completes every WIDTH+2 clocks.
// ---------------------------------------------------------------------------

// One-bit full adder cell.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_shift;

    // The single full-adder slice: always looks at bit 0 of the operand
    // shift registers and the carry left over from the previous bit.
    fa u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    // New sum bit enters at the MSB, so after WIDTH shifts the first
    // (LSB) bit has walked all the way down to bit 0. A one-bit sum
    // register has no upper bits to keep, hence the split.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_shift = fa_s;
        end else begin : g_sum_wn
            assign sum_shift = {fa_s, sum_sr[WIDTH-1:1]};
        end
    endgenerate

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // cnt counts completed bits before this edge; the edge
                // that processes bit WIDTH-1 is the last shift.
                if (cnt == CNT_LAST) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // in_valid is deliberately not looked at here: a
                // simultaneous request waits until IDLE is reached.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs, decoded from the state register alone so neither
    // handshake has a combinational path through this stage.
    // ---------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    sum_sr <= sum_shift;
                    carry  <= fa_c;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + 1'b1;
                end
                default: begin
                    // HOLD: everything frozen so sum/cout stay stable
                    // under any amount of backpressure.
                end
            endcase
        end
    end

    // In HOLD the carry register holds the carry-out of bit WIDTH-1.
    assign sum  = sum_sr;
    assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH=8). Expected results come from
// plain integer addition a + b + cin at WIDTH+1 bits; expected timing comes
// from the stated latency (WIDTH clocks) and throughput (WIDTH+2 clocks).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: exact WIDTH+1-bit sum.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // One complete operation: accept, check exact latency, hold with
    // backpressure for 'hold' cycles while scrambling the inputs, then
    // release with in_valid also high and confirm only the output
    // handshake is taken.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input int hold, input string tag);
        logic [W:0] exp;
        exp = model(ta, tb, tc);
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        cin       = tc;
        out_ready = 1'b0;
        @(negedge clk);                       // accepting edge has passed
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            check({tag, "_latency"}, 32'(out_valid), (k == W) ? 32'd1 : 32'd0);
        end
        check({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
        check({tag, "_cout"}, 32'(cout), 32'(exp[W]));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            a        = W'($urandom);
            b        = W'($urandom);
            cin      = 1'($urandom);
            @(negedge clk);
            check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_bp_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_bp_sum"}, 32'(sum), 32'(exp[W-1:0]));
            check({tag, "_bp_cout"}, 32'(cout), 32'(exp[W]));
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);                       // output handshake has passed
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_release_ready"}, 32'(in_ready), 32'd1);
    endtask

    logic [W-1:0] bb_a [3];
    logic [W-1:0] bb_b [3];
    logic         bb_c [3];
    logic [W:0]   exp_q [$];
    logic [W:0]   e;
    int           idx;
    int           res;
    int           last_acc;
    int           seen;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset state, before any clock edge.
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases.
        run_op(8'h3C, 8'h5A, 1'b0, 0, "basic");
        run_op(8'hFF, 8'h01, 1'b0, 1, "carry_ff01");
        run_op(8'hFF, 8'hFF, 1'b1, 2, "carry_ffff1");
        run_op(8'h00, 8'h00, 1'b1, 0, "carry_cin");
        run_op(8'hA5, 8'h5B, 1'b1, 5, "backpressure");

        // Randomized operations with random backpressure.
        for (int r = 0; r < 20; r++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), "random");
        end

        // Back-to-back with in_valid and out_ready held high.
        bb_a[0] = 8'h01; bb_b[0] = 8'h02; bb_c[0] = 1'b0;
        bb_a[1] = 8'h07; bb_b[1] = 8'h09; bb_c[1] = 1'b1;
        bb_a[2] = 8'h80; bb_b[2] = 8'h80; bb_c[2] = 1'b0;
        idx       = 0;
        res       = 0;
        last_acc  = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && res < 3; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                e = exp_q.pop_front();
                check("b2b_sum", 32'(sum), 32'(e[W-1:0]));
                check("b2b_cout", 32'(cout), 32'(e[W]));
                res++;
            end
            if (in_ready && idx < 3) begin
                in_valid = 1'b1;
                a        = bb_a[idx];
                b        = bb_b[idx];
                cin      = bb_c[idx];
                exp_q.push_back(model(bb_a[idx], bb_b[idx], bb_c[idx]));
                if (last_acc >= 0) begin
                    check("b2b_interval", 32'(cyc - last_acc), 32'(W + 2));
                end
                last_acc = cyc;
                idx++;
            end else if (idx == 3) begin
                in_valid = 1'b0;
            end
        end
        check("b2b_results", 32'(res), 32'd3);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset asserted mid-clock while in HOLD: outputs clear at once.
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'h77; b = 8'h11; cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (W + 1) @(negedge clk);
        check("hold_before_reset", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_sum", 32'(sum), 32'd0);
        check("midreset_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset 4 clocks into SHIFT: the operation must never complete.
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'hAA; b = 8'h55; cin = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("shiftreset_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 2 * W; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("discarded_op", 32'(seen), 32'd0);
        run_op(8'h10, 8'h20, 1'b0, 0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
